// File: rtl/wb_defs_pkg.sv
// Shared Wishbone slave definitions: FSM state encoding and lane/line geometry helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package wb_defs_pkg;

  // Request phase, wait-state countdown, single-cycle termination.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // Number of byte-lane selects on a bus of data_width bits.
  function automatic int sel_width(input int data_width, input int granularity);
    return data_width / granularity;
  endfunction

  // Number of low address bits that fall inside one line.
  function automatic int line_depth(input int data_width, input int granularity);
    return $clog2(data_width / granularity);
  endfunction

endpackage

// File: rtl/sp_be_ram.sv
// Single-port line RAM with per-lane write enables; contents are never cleared.
// Latency: write commits at the clock edge, read data is registered (valid one edge after addr).
// Backpressure: none; accepts an access every cycle.
module sp_be_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int LANE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LANES      = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic [LANES-1:0]      we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdat_q;

  // Byte-lane write: only the enabled lanes of the addressed line change.
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we[k]) begin
        mem[addr][k*LANE_WIDTH +: LANE_WIDTH] <= wdat[k*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Registered full-line read, performed every cycle.
  always_ff @(posedge clk) begin
    rdat_q <= mem[addr];
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic line-memory responder; optional out-of-range error via WB_MEM_SLAVE_ERR_EN.
// Latency: ack (or err) one cycle, from 1+LATENCY edges after the accepting edge.
// Backpressure: one request in flight; next accept no earlier than 3+LATENCY edges after the last.
module wb_mem_slave
  import wb_defs_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 128,
  parameter int                    ADDR_WIDTH       = 32,
  parameter int                    ADDR_GRANULARITY = 8,
  parameter int                    MEM_DEPTH        = 10,
  parameter int                    LATENCY          = 1,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ADDR_WIDTH-1:0]                    wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                    wb_dat_i,
  output logic [DATA_WIDTH-1:0]                    wb_dat_o,
  input  logic                                     wb_we_i,
  input  logic [DATA_WIDTH/ADDR_GRANULARITY-1:0]   wb_sel_i,
  input  logic                                     wb_stb_i,
  input  logic                                     wb_cyc_i,
  output logic                                     wb_ack_o,
  output logic                                     wb_err_o,
  output logic                                     wb_rty_o
);

  localparam int SEL_WIDTH  = sel_width(DATA_WIDTH, ADDR_GRANULARITY);
  localparam int LINE_DEPTH = line_depth(DATA_WIDTH, ADDR_GRANULARITY);

  wb_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MEM_DEPTH-1:0]  idx_q, idx_d;
  logic                  we_q, we_d;
  logic                  bad_q, bad_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  req;
  logic                  in_range;
  logic [MEM_DEPTH-1:0]  bus_idx;
  logic [SEL_WIDTH-1:0]  ram_we;
  logic [MEM_DEPTH-1:0]  ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdat;

  assign req = wb_cyc_i & wb_stb_i;

  // Line index relative to BASE_ADDR; bits above the index wrap (alias) silently.
  assign bus_idx = MEM_DEPTH'((wb_adr_i - BASE_ADDR) >> LINE_DEPTH);

`ifdef WB_MEM_SLAVE_ERR_EN
  assign in_range = (wb_adr_i >= BASE_ADDR) &&
                    (((wb_adr_i - BASE_ADDR) >> (LINE_DEPTH + MEM_DEPTH)) == '0);
`else
  assign in_range = 1'b1;
`endif

  // Write commits on the accepting edge; reset must never let a presented request slip in.
  assign ram_we   = (!rst && state_q == ST_IDLE && req && wb_we_i && in_range) ? wb_sel_i : '0;
  // During the request edge read the bus line, afterwards keep re-reading the latched one.
  assign ram_addr = (state_q == ST_IDLE) ? bus_idx : idx_q;

  sp_be_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANE_WIDTH (ADDR_GRANULARITY),
    .ADDR_WIDTH (MEM_DEPTH),
    .LANES      (SEL_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdat (wb_dat_i),
    .rdat (ram_rdat)
  );

  // State and response registers, synchronously reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Request attributes; only meaningful once a request has been accepted, so no reset.
  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    we_q  <= we_d;
    bad_q <= bad_d;
  end

  // Next state: an abort (cyc low) in WAIT wins over a due response; RESP never accepts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: latch the request, count wait states, raise one termination cycle.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    we_d  = we_q;
    bad_d = bad_q;
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = dat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          cnt_d = 4'(LATENCY);
          idx_d = bus_idx;
          we_d  = wb_we_i;
          bad_d = !in_range;
        end
      end
      ST_WAIT: begin
        if (wb_cyc_i) begin
          if (cnt_q == '0) begin
            ack_d = !bad_q;
            err_d = bad_q;
            if (!we_q && !bad_q) begin
              dat_d = ram_rdat;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Bench for wb_mem_slave: three instances (latency 1/0/7, different depths and bases).
// Latency: n/a.
// Backpressure: the master model holds stb/cyc until it has seen the termination cycle.
module tb_wb_mem_slave;

  localparam int NDUT = 3;
`ifdef WB_MEM_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic int p_lat(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 0 : 7);
  endfunction
  function automatic int p_md(input int g);
    return (g == 0) ? 10 : 4;
  endfunction
  function automatic logic [31:0] p_base(input int g);
    return (g == 1) ? 32'h100 : 32'h0;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  adr   [NDUT];
  logic [127:0] dat_i [NDUT];
  logic [127:0] dat_o [NDUT];
  logic         we    [NDUT];
  logic [15:0]  sel   [NDUT];
  logic         stb   [NDUT];
  logic         cyc   [NDUT];
  logic         ack   [NDUT];
  logic         err   [NDUT];
  logic         rty   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_mem_slave #(
      .MEM_DEPTH (p_md(g)),
      .LATENCY   (p_lat(g)),
      .BASE_ADDR (p_base(g))
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .wb_adr_i (adr[g]),
      .wb_dat_i (dat_i[g]),
      .wb_dat_o (dat_o[g]),
      .wb_we_i  (we[g]),
      .wb_sel_i (sel[g]),
      .wb_stb_i (stb[g]),
      .wb_cyc_i (cyc[g]),
      .wb_ack_o (ack[g]),
      .wb_err_o (err[g]),
      .wb_rty_o (rty[g])
    );
  end

  // Reference model: one line array per instance plus the last value dat_o should hold.
  logic [127:0] mdl      [NDUT][1024];
  logic [127:0] last_dat [NDUT];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit out_of_range(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = a - p_base(d);
    return (a < p_base(d)) || ((off >> (4 + p_md(d))) != 32'd0);
  endfunction

  function automatic int line_of(input int d, input logic [31:0] a);
    logic [31:0] off;
    off = (a - p_base(d)) / 32'd16;
    return int'(off % (32'd1 << p_md(d)));
  endfunction

  // One full transaction, with stb held until the cycle after the termination was seen.
  task automatic xact(input int d, input bit w, input logic [31:0] a,
                      input logic [127:0] di, input logic [15:0] s);
    int l, first, nack, nerr, nboth, nrty, ln;
    bit exp_err;
    logic [127:0] exp_dat, dat_at, cur;
    l = p_lat(d); first = -1; nack = 0; nerr = 0; nboth = 0; nrty = 0;
    dat_at = 'x;
    exp_err = ERR_EN && out_of_range(d, a);
    ln = line_of(d, a);
    @(negedge clk);
    adr[d] = a; dat_i[d] = di; we[d] = w; sel[d] = s; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    exp_dat = last_dat[d];
    if (!exp_err) begin
      if (w) begin
        cur = mdl[d][ln];
        for (int k = 0; k < 16; k++) if (s[k]) cur[k*8 +: 8] = di[k*8 +: 8];
        mdl[d][ln] = cur;
      end else begin
        exp_dat = mdl[d][ln];
      end
    end
    for (int k = 1; k <= 2*l + 4; k++) begin
      @(posedge clk); #1;
      if (ack[d] && err[d]) nboth++;
      if (ack[d]) nack++;
      if (err[d]) nerr++;
      if (rty[d]) nrty++;
      if ((ack[d] || err[d]) && first < 0) begin
        first = k;
        dat_at = dat_o[d];
      end
      if (k == l + 2) begin
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      end
    end
    check($sformatf("d%0d resp_pos a=%h", d, a), 128'(first), 128'(l + 1));
    check($sformatf("d%0d ack_cnt a=%h", d, a), 128'(nack), 128'(exp_err ? 0 : 1));
    check($sformatf("d%0d err_cnt a=%h", d, a), 128'(nerr), 128'(exp_err ? 1 : 0));
    check($sformatf("d%0d ack_err_both", d), 128'(nboth), 128'(0));
    check($sformatf("d%0d rty", d), 128'(nrty), 128'(0));
    check($sformatf("d%0d dat a=%h we=%0d", d, a, w), dat_at, exp_dat);
    check($sformatf("d%0d dat_hold", d), dat_o[d], exp_dat);
    last_dat[d] = exp_dat;
  endtask

  // Read whose cycle is dropped right after acceptance: no termination may follow.
  task automatic abort_read(input int d, input logic [31:0] a);
    int seen;
    seen = 0;
    @(negedge clk);
    adr[d] = a; we[d] = 1'b0; sel[d] = 16'hFFFF; cyc[d] = 1'b1; stb[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc[d] = 1'b0; stb[d] = 1'b0;
    for (int k = 1; k <= p_lat(d) + 4; k++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) seen++;
    end
    check($sformatf("d%0d abort_resp", d), 128'(seen), 128'(0));
    check($sformatf("d%0d abort_dat", d), dat_o[d], last_dat[d]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rnd;
    logic [127:0] pat;
    logic [15:0]  s;
    logic [31:0]  a;
    int d;
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      adr[i] = '0; dat_i[i] = '0; we[i] = 1'b0; sel[i] = '0; stb[i] = 1'b0; cyc[i] = 1'b0;
      last_dat[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d rst_ack", i), 128'(ack[i]), 128'(0));
      check($sformatf("d%0d rst_err", i), 128'(err[i]), 128'(0));
      check($sformatf("d%0d rst_rty", i), 128'(rty[i]), 128'(0));
      check($sformatf("d%0d rst_dat", i), dat_o[i], 128'(0));
    end
    @(negedge clk);
    rst = 1'b0;

    // Give every reachable line a known value.
    for (int ln = 0; ln < 32; ln++)
      xact(0, 1'b1, 32'(ln * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    for (int ln = 0; ln < 16; ln++) begin
      xact(1, 1'b1, 32'h100 + 32'(ln * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
      xact(2, 1'b1, 32'(ln * 16), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);
    end

    // Full-line write then read back of line 0x10.
    pat = 128'h0123456789ABCDEF0123456789ABCDEF;
    xact(0, 1'b1, 32'h100, pat, 16'hFFFF);
    xact(0, 1'b0, 32'h100, '0, 16'h0000);
    check("line10_literal", dat_o[0], pat);

    // Partial write of lanes 0-3 into an all-0xAA line.
    xact(0, 1'b1, 32'h110, {16{8'hAA}}, 16'hFFFF);
    xact(0, 1'b1, 32'h110, {96'h0, 32'hDEADBEEF}, 16'h000F);
    xact(0, 1'b0, 32'h11C, '0, 16'h0000);
    check("partial_literal", dat_o[0], {{12{8'hAA}}, 32'hDEADBEEF});

    // Zero select is acked with no change; out-of-range write on the 16-line instance.
    xact(0, 1'b1, 32'h110, '1, 16'h0000);
    xact(0, 1'b0, 32'h110, '0, 16'hFFFF);
    xact(2, 1'b1, 32'h100, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 16'hFFFF);
    xact(2, 1'b0, 32'h000, '0, 16'hFFFF);
    xact(1, 1'b0, 32'h0F0, '0, 16'hFFFF);
    xact(1, 1'b0, 32'h200, '0, 16'hFFFF);

    // Aborts on the zero- and long-latency instances, each followed by a normal read.
    abort_read(2, 32'h020);
    xact(2, 1'b0, 32'h020, '0, 16'hFFFF);
    abort_read(1, 32'h130);
    xact(1, 1'b0, 32'h130, '0, 16'hFFFF);

    // Randomized mix of reads, writes, zero selects, out-of-range addresses and aborts.
    for (int it = 0; it < 240; it++) begin
      d = $urandom_range(0, NDUT - 1);
      case (d)
        0: a = 32'($urandom_range(0, 32'h1FF));
        1: a = 32'($urandom_range(0, 32'h3FF));
        default: a = 32'($urandom_range(0, 32'h1FF));
      endcase
      rnd = {$urandom, $urandom, $urandom, $urandom};
      s = 16'($urandom);
      if ($urandom_range(0, 7) == 0) s = 16'h0000;
      if ($urandom_range(0, 15) == 0) abort_read(d, a);
      else xact(d, 1'($urandom_range(0, 1)), a, rnd, s);
    end

    // Reset during the wait of a write: the write stays, outputs clear.
    xact(0, 1'b0, 32'h100, '0, 16'hFFFF);
    pat = 128'h5A5A_0F0F_1234_5678_9ABC_DEF0_1357_2468;
    @(negedge clk);
    adr[0] = 32'h120; dat_i[0] = pat; we[0] = 1'b1; sel[0] = 16'hFFFF; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    mdl[0][18] = pat;
    @(negedge clk);
    rst = 1'b1; cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d midrst_ack", i), 128'(ack[i]), 128'(0));
      check($sformatf("d%0d midrst_err", i), 128'(err[i]), 128'(0));
      check($sformatf("d%0d midrst_dat", i), dat_o[i], 128'(0));
      last_dat[i] = '0;
    end
    @(negedge clk);
    rst = 1'b0;
    xact(0, 1'b0, 32'h120, '0, 16'hFFFF);
    check("after_rst_literal", dat_o[0], pat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
